// File: rtl/rst_release_seq.sv
`timescale 1ns/1ps
// rst_release_seq
//
// Reset release sequencer for the set-on-reset flops of the FPGA core.
// A board reset asserts every staged reset output at once, without waiting
// for a clock. Release is synchronous to clk and happens one stage at a time,
// bit 0 first, with STAGE_GAP clk cycles between stages. Software can replay
// the same staged release through a soft-reset request/acknowledge handshake.
//
// Parameters
//   NUM_STAGES  number of staged reset outputs (>= 1)
//   SYNC_DEPTH  flops in the deassertion synchronizer (>= 2)
//   STAGE_GAP   clk cycles between consecutive stage releases (>= 1)
//
// Ports
//   clk           core clock
//   rst           board reset, asynchronous, active-high
//   soft_rst_req  soft-reset request, level-sampled only while idle
//   rst_out       per-stage reset, active-high, bit 0 releases first
//   all_released  every stage released and the sequencer idle
//   busy          sequencer is asserting or releasing
//   soft_rst_ack  one-cycle pulse when a soft-initiated sequence completes
module rst_release_seq #(
  parameter int NUM_STAGES = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int STAGE_GAP  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  all_released,
  output logic                  busy,
  output logic                  soft_rst_ack
);

  localparam int CNT_W = $clog2(STAGE_GAP + 1);
  localparam int STG_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] GAP_V    = CNT_W'(STAGE_GAP);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);

  localparam logic [1:0] S_ASSERT  = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_IDLE    = 2'd2;

  // Illegal parameterisations are stopped at elaboration.
  if (NUM_STAGES < 1) begin : g_bad_num_stages
    $error("rst_release_seq: NUM_STAGES must be >= 1");
  end
  if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
    $error("rst_release_seq: SYNC_DEPTH must be >= 2");
  end
  if (STAGE_GAP < 1) begin : g_bad_stage_gap
    $error("rst_release_seq: STAGE_GAP must be >= 1");
  end

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [STG_W-1:0]      stg;
  logic                  soft_flag;
  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_rst;

  logic                  tick;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  fire;
  logic                  soft_go;
  logic [NUM_STAGES-1:0] stage_mask;

  // ---- Deassertion synchronizer: set asynchronously, drains zeros on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b0};
    end
  end

  assign sync_rst = sync_q[SYNC_DEPTH-1];

  // ---- Gap timing.
  // The edge that leaves ASSERT already counts as the first edge of the
  // first gap, so a hard release drops stage 0 STAGE_GAP-1 edges after
  // entering RELEASE. A soft start leaves cnt at 0, so its first stage drops
  // a full STAGE_GAP edges after the request edge. With STAGE_GAP=1 the
  // ASSERT exit edge itself releases stage 0.
  assign tick    = ((state == S_ASSERT) && !sync_rst) || (state == S_RELEASE);
  assign cnt_inc = (state == S_ASSERT) ? CNT_W'(1) : (cnt + CNT_W'(1));
  assign fire    = tick && (cnt_inc == GAP_V);

  // The request is already synchronous to clk, so it skips the synchronizer.
  assign soft_go = (state == S_IDLE) && soft_rst_req;

  always_comb begin
    stage_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stg == STG_W'(i)) begin
        stage_mask[i] = 1'b1;
      end
    end
  end

  // ---- Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_ASSERT;
      cnt          <= '0;
      stg          <= '0;
      soft_flag    <= 1'b0;
      rst_out      <= '1;
      all_released <= 1'b0;
      soft_rst_ack <= 1'b0;
    end else begin
      soft_rst_ack <= 1'b0;
      if (soft_go) begin
        rst_out      <= '1;
        all_released <= 1'b0;
        state        <= S_RELEASE;
        cnt          <= '0;
        stg          <= '0;
        soft_flag    <= 1'b1;
      end else if (fire) begin
        // Bits only ever clear here, so a released stage stays released.
        rst_out <= rst_out & ~stage_mask;
        cnt     <= '0;
        stg     <= stg + STG_W'(1);
        if (stg == LAST_STG) begin
          state        <= S_IDLE;
          all_released <= 1'b1;
          soft_rst_ack <= soft_flag;
          soft_flag    <= 1'b0;
        end else begin
          state <= S_RELEASE;
        end
      end else if (tick) begin
        cnt   <= cnt_inc;
        state <= S_RELEASE;
      end
    end
  end

  // Decoded straight from the state flops, so it asserts with rst as well.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rst_release_seq.sv
`timescale 1ns/1ps
module tb_rst_release_seq;

  localparam int NS = 4;
  localparam int SD = 2;
  localparam int SG = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [NS-1:0] rst_out;
  logic          ar;
  logic          busy;
  logic          ack;

  logic [0:0]    rst_out1;
  logic          ar1;
  logic          busy1;
  logic          ack1;
  logic          req1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rst_release_seq #(.NUM_STAGES(NS), .SYNC_DEPTH(SD), .STAGE_GAP(SG)) u_dut (
    .clk(clk), .rst(rst), .soft_rst_req(req),
    .rst_out(rst_out), .all_released(ar), .busy(busy), .soft_rst_ack(ack)
  );

  rst_release_seq #(.NUM_STAGES(1), .SYNC_DEPTH(2), .STAGE_GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .soft_rst_req(req1),
    .rst_out(rst_out1), .all_released(ar1), .busy(busy1), .soft_rst_ack(ack1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = held in reset, 1 = hard release, 2 = soft
  // release, 3 = idle. t counts clk edges since the sequence origin (rst
  // falling for hard, the request edge for soft).
  int mode  = 0;
  int t     = 0;
  bit ack_m = 1'b0;
  bit mdl_on = 1'b0;

  always @(posedge clk or posedge rst or negedge rst) begin
    if (rst) begin
      mode  = 0;
      ack_m = 1'b0;
    end else if (mode == 0) begin
      mode = 1;
      t    = 0;
    end else begin
      case (mode)
        1: begin
          t++;
          if (t >= SD + NS * SG) mode = 3;
        end
        2: begin
          t++;
          if (t == NS * SG) begin
            mode  = 3;
            ack_m = 1'b1;
          end
        end
        default: begin
          ack_m = 1'b0;
          if (req) begin
            mode = 2;
            t    = 0;
          end
        end
      endcase
    end
  end

  function automatic logic [NS-1:0] m_rst_out();
    logic [NS-1:0] v;
    v = '1;
    for (int k = 0; k < NS; k++) begin
      case (mode)
        1:       v[k] = (t < SD + (k + 1) * SG);
        2:       v[k] = (t < (k + 1) * SG);
        3:       v[k] = 1'b0;
        default: v[k] = 1'b1;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    #1;
    if (mdl_on) begin
      chk("mdl_rst_out", 32'(rst_out), 32'(m_rst_out()));
      chk("mdl_all_released", 32'(ar), 32'(mode == 3));
      chk("mdl_busy", 32'(busy), 32'(mode != 3));
      chk("mdl_ack", 32'(ack), 32'((mode == 3) && ack_m));
    end
  end

  int acks[$];
  bit sawack;
  int hold;
  int r;
  int d;

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rst_out", 32'(rst_out), 32'hF);
    chk("reset_all_released", 32'(ar), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_rst_out1", 32'(rst_out1), 32'h1);
    mdl_on = 1'b1;

    // Hard release with literal edge expectations.
    @(negedge clk);
    rst = 1'b0;
    sawack = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      #1;
      if (ack) sawack = 1'b1;
      if (e == 9)  chk("hard_e9", 32'(rst_out), 32'hF);
      if (e == 10) chk("hard_e10", 32'(rst_out), 32'hE);
      if (e == 18) chk("hard_e18", 32'(rst_out), 32'hC);
      if (e == 26) chk("hard_e26", 32'(rst_out), 32'h8);
      if (e == 33) chk("hard_e33_ar", 32'(ar), 32'h0);
      if (e == 34) begin
        chk("hard_e34_rst_out", 32'(rst_out), 32'h0);
        chk("hard_e34_ar", 32'(ar), 32'h1);
        chk("hard_e34_busy", 32'(busy), 32'h0);
      end
      if (e == 2) chk("one_e2", 32'(rst_out1), 32'h1);
      if (e == 3) begin
        chk("one_e3_rst_out", 32'(rst_out1), 32'h0);
        chk("one_e3_ar", 32'(ar1), 32'h1);
      end
    end
    chk("hard_no_ack", 32'(sawack), 32'h0);

    // Single-cycle soft request.
    repeat (3) @(posedge clk);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    chk("soft_E_rst_out", 32'(rst_out), 32'hF);
    chk("soft_E_ar", 32'(ar), 32'h0);
    @(negedge clk);
    req = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk);
      #1;
      if (e == 8)  chk("soft_e8", 32'(rst_out), 32'hE);
      if (e == 16) chk("soft_e16", 32'(rst_out), 32'hC);
      if (e == 24) chk("soft_e24", 32'(rst_out), 32'h8);
      if (e == 31) chk("soft_e31_ack", 32'(ack), 32'h0);
      if (e == 32) begin
        chk("soft_e32_ack", 32'(ack), 32'h1);
        chk("soft_e32_ar", 32'(ar), 32'h1);
      end
      if (e == 33) chk("soft_e33_ack", 32'(ack), 32'h0);
    end

    // Sub-cycle rst glitch while idle.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("glitch_async_rst_out", 32'(rst_out), 32'hF);
    chk("glitch_async_busy", 32'(busy), 32'h1);
    #1 rst = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      #1;
      if (e == 33) chk("glitch_e33_ar", 32'(ar), 32'h0);
      if (e == 34) chk("glitch_e34_ar", 32'(ar), 32'h1);
    end

    // rst at E+20 of a soft sequence.
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_rst_out", 32'(rst_out), 32'hF);
    chk("abort_ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sawack = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (ack) sawack = 1'b1;
      if (e == 34) chk("abort_e34_ar", 32'(ar), 32'h1);
    end
    chk("abort_no_ack", 32'(sawack), 32'h0);

    // Held request: back-to-back sequences.
    @(negedge clk);
    req = 1'b1;
    for (int e = 1; e <= 140; e++) begin
      @(posedge clk);
      #1;
      if (ack) acks.push_back(e);
    end
    @(negedge clk);
    req = 1'b0;
    chk("held_ack_count", 32'(acks.size()), 32'd4);
    if (acks.size() > 0) chk("held_first_ack", 32'(acks[0]), 32'd33);
    for (int i = 1; i < acks.size(); i++) begin
      chk("held_ack_period", 32'(acks[i] - acks[i-1]), 32'd33);
    end
    repeat (40) @(posedge clk);

    // Randomized requests and rst pulses, checked by the model every cycle.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 999));
      if (r < 4) begin
        #1 rst = 1'b1;
        d = 2 + 10 * int'($urandom_range(0, 3));
        #(d) rst = 1'b0;
      end else if (hold > 0) begin
        req = 1'b1;
        hold--;
      end else begin
        req = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 99) == 0) hold = int'($urandom_range(10, 80));
      end
    end
    @(negedge clk);
    req = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
